// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_ctrl
// Function : Frames FIFO I/Q samples into the FFT sink and drains each result
//            frame into the packed 32-bit downstream interface.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl #(
    parameter int FFT_LEN = 8192,
    parameter int CNT_W   = 13,
    parameter int STARTUP = 20,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          fifo_rdempty,
    input  logic [DW-1:0] fifo_re,
    input  logic [DW-1:0] fifo_im,
    output logic          fifo_rdreq,
    output logic          fft_reset_n,
    input  logic          fft_sink_ready,
    output logic          fft_sink_valid,
    output logic          fft_sink_sop,
    output logic          fft_sink_eop,
    output logic [DW-1:0] fft_sink_real,
    output logic [DW-1:0] fft_sink_imag,
    input  logic          fft_source_valid,
    input  logic          fft_source_sop,
    input  logic          fft_source_eop,
    input  logic [DW-1:0] fft_source_real,
    input  logic [DW-1:0] fft_source_imag,
    input  logic [5:0]    fft_source_exp,
    output logic          fft_source_ready,
    output logic          out_valid,
    output logic [31:0]   out_data,
    input  logic          out_ready,
    output logic [5:0]    exp_reg,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);

    localparam int                  c_hold_w    = (STARTUP > 1) ? $clog2(STARTUP) : 1;
    localparam logic [CNT_W-1:0]    c_last_idx  = CNT_W'(FFT_LEN - 1);
    localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(STARTUP - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOLD     = 3'd1,
        S_FEED     = 3'd2,
        S_WAIT_OUT = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_in_cnt;
    logic [CNT_W-1:0]    r_out_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_fft_reset_n;
    logic                r_err;
    logic [5:0]          r_exp;
    logic                w_transfer;
    logic                w_beat;
    logic                w_set_err;

    // Sample data is a straight wire from the show-ahead FIFO; only the
    // strobes are qualified by state.
    assign fft_sink_real = fifo_re;
    assign fft_sink_imag = fifo_im;
    assign fft_reset_n   = r_fft_reset_n;
    assign err           = r_err;
    assign exp_reg       = r_exp;
    assign busy          = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        fifo_rdreq       = 1'b0;
        fft_sink_valid   = 1'b0;
        fft_sink_sop     = 1'b0;
        fft_sink_eop     = 1'b0;
        fft_source_ready = 1'b0;
        out_valid        = 1'b0;
        out_data         = '0;
        frame_done       = 1'b0;
        w_transfer       = 1'b0;
        w_beat           = 1'b0;
        w_set_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_hold_cnt == '0) w_state_nxt = S_FEED;
            end
            S_FEED: begin
                fft_sink_valid = !fifo_rdempty;
                fft_sink_sop   = !fifo_rdempty && (r_in_cnt == '0);
                fft_sink_eop   = !fifo_rdempty && (r_in_cnt == c_last_idx);
                w_transfer     = !fifo_rdempty && fft_sink_ready;
                fifo_rdreq     = w_transfer;
                if (w_transfer && (r_in_cnt == c_last_idx)) w_state_nxt = S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
                // A frame start is left on the bus for DRAIN to consume;
                // anything else is flushed and flagged.
                if (fft_source_valid) begin
                    if (fft_source_sop) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        fft_source_ready = 1'b1;
                        w_set_err        = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                fft_source_ready = out_ready;
                out_valid        = fft_source_valid;
                out_data         = {fft_source_imag, fft_source_real};
                w_beat           = fft_source_valid && out_ready;
                if (w_beat) begin
                    if (fft_source_eop) begin
                        w_state_nxt = S_DONE;
                        if (r_out_cnt != c_last_idx) w_set_err = 1'b1;
                    end else if (r_out_cnt == c_last_idx) begin
                        w_set_err = 1'b1;
                    end
                end
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = start ? S_FEED : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_fft_reset_n <= 1'b0;
            r_exp         <= '0;
            r_err         <= 1'b0;
        end else begin
            // Core leaves reset together with the first FEED cycle and stays
            // out of reset across back-to-back frames.
            r_fft_reset_n <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HOLD);
            if (r_state == S_IDLE) begin
                r_hold_cnt <= c_hold_init;
            end else if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
            if (w_transfer) begin
                r_in_cnt <= (r_in_cnt == c_last_idx) ? '0 : r_in_cnt + 1'b1;
            end
            if (w_beat) begin
                r_out_cnt <= fft_source_eop ? '0 : r_out_cnt + 1'b1;
            end
            if (w_beat && fft_source_sop) r_exp <= fft_source_exp;
            if (w_set_err) r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_ctrl
// Function : Randomised self-checking bench for fft_frame_ctrl (FFT_LEN=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_ctrl;

    localparam int LEN = 8;
    localparam int CW  = 3;
    localparam int SU  = 4;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          fifo_rdempty;
    logic [DW-1:0] fifo_re;
    logic [DW-1:0] fifo_im;
    logic          fifo_rdreq;
    logic          fft_reset_n;
    logic          fft_sink_ready;
    logic          fft_sink_valid;
    logic          fft_sink_sop;
    logic          fft_sink_eop;
    logic [DW-1:0] fft_sink_real;
    logic [DW-1:0] fft_sink_imag;
    logic          fft_source_valid;
    logic          fft_source_sop;
    logic          fft_source_eop;
    logic [DW-1:0] fft_source_real;
    logic [DW-1:0] fft_source_imag;
    logic [5:0]    fft_source_exp;
    logic          fft_source_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_ready;
    logic [5:0]    exp_reg;
    logic          busy;
    logic          frame_done;
    logic          err;

    int         n_checks  = 0;
    int         n_errors  = 0;
    bit         exp_err   = 1'b0;
    logic [5:0] exp_model = 6'd0;

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .FFT_LEN (LEN),
        .CNT_W   (CW),
        .STARTUP (SU),
        .DW      (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .fifo_rdempty     (fifo_rdempty),
        .fifo_re          (fifo_re),
        .fifo_im          (fifo_im),
        .fifo_rdreq       (fifo_rdreq),
        .fft_reset_n      (fft_reset_n),
        .fft_sink_ready   (fft_sink_ready),
        .fft_sink_valid   (fft_sink_valid),
        .fft_sink_sop     (fft_sink_sop),
        .fft_sink_eop     (fft_sink_eop),
        .fft_sink_real    (fft_sink_real),
        .fft_sink_imag    (fft_sink_imag),
        .fft_source_valid (fft_source_valid),
        .fft_source_sop   (fft_source_sop),
        .fft_source_eop   (fft_source_eop),
        .fft_source_real  (fft_source_real),
        .fft_source_imag  (fft_source_imag),
        .fft_source_exp   (fft_source_exp),
        .fft_source_ready (fft_source_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .exp_reg          (exp_reg),
        .busy             (busy),
        .frame_done       (frame_done),
        .err              (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        fifo_rdempty     = 1'b1;
        fifo_re          = '0;
        fifo_im          = '0;
        fft_sink_ready   = 1'b0;
        fft_source_valid = 1'b0;
        fft_source_sop   = 1'b0;
        fft_source_eop   = 1'b0;
        fft_source_real  = '0;
        fft_source_imag  = '0;
        fft_source_exp   = '0;
        out_ready        = 1'b0;
    endtask

    // Pushes samples until n_stop have been accepted. Expected strobes come
    // from the counted number of accepted samples, not from DUT state.
    task automatic run_feed(input bit from_idle, input int n_stop,
                            input int empty_pct, input int notready_pct);
        int idx  = 0;
        int cyc  = 0;
        int hold = 0;
        bit v;
        bit t;
        if (from_idle) begin
            fifo_rdempty   = 1'b0;
            fft_sink_ready = 1'b1;
            step();
            while (!fft_reset_n && hold < 50) begin
                n_checks++;
                if ({busy, fft_sink_valid, fifo_rdreq} !== 3'b100) begin
                    n_errors++;
                    $display("FAIL hold_outputs cyc=%0d busy/valid/rdreq got=%b want=100",
                             hold, {busy, fft_sink_valid, fifo_rdreq});
                end
                hold++;
                step();
            end
            n_checks++;
            if (hold != SU) begin
                n_errors++;
                $display("FAIL hold_length got=%0d want=%0d", hold, SU);
            end
        end
        while (idx < n_stop && cyc < 400) begin
            fifo_rdempty   = ($urandom_range(99) < empty_pct);
            fft_sink_ready = ($urandom_range(99) >= notready_pct);
            fifo_re        = DW'($urandom);
            fifo_im        = DW'($urandom);
            #2;
            v = !fifo_rdempty;
            t = v && fft_sink_ready;
            n_checks++;
            if ({fft_sink_valid, fifo_rdreq, fft_sink_sop, fft_sink_eop, fft_reset_n} !==
                {v, t, v && (idx == 0), v && (idx == LEN - 1), 1'b1}) begin
                n_errors++;
                $display("FAIL feed_strobes idx=%0d valid/rdreq/sop/eop/rstn got=%b want=%b",
                         idx, {fft_sink_valid, fifo_rdreq, fft_sink_sop, fft_sink_eop, fft_reset_n},
                         {v, t, v && (idx == 0), v && (idx == LEN - 1), 1'b1});
            end
            if (v) begin
                n_checks++;
                if ({fft_sink_imag, fft_sink_real} !== {fifo_im, fifo_re}) begin
                    n_errors++;
                    $display("FAIL feed_data idx=%0d got=%h want=%h", idx,
                             {fft_sink_imag, fft_sink_real}, {fifo_im, fifo_re});
                end
            end
            if (t) idx++;
            cyc++;
            step();
        end
        if (idx < n_stop) begin
            n_checks++;
            n_errors++;
            $display("FAIL feed_timeout got=%0d want=%0d transfers", idx, n_stop);
        end else if (n_stop == LEN) begin
            // Waiting for the transform: the FIFO must be left alone.
            fifo_rdempty   = 1'b0;
            fft_sink_ready = 1'b1;
            #2;
            n_checks++;
            if ({busy, fft_sink_valid, fifo_rdreq, fft_source_ready, out_valid} !== 5'b10000) begin
                n_errors++;
                $display("FAIL wait_out_idle busy/valid/rdreq/srdy/ovld got=%b want=10000",
                         {busy, fft_sink_valid, fifo_rdreq, fft_source_ready, out_valid});
            end
        end
    endtask

    // Plays one result frame whose eop sits on beat eop_at, optionally
    // preceded by a stray beat, with random source gaps and out_ready.
    task automatic run_drain(input int eop_at, input bit stray,
                             input int ready_pct, input logic [5:0] exp_val);
        int k        = 0;
        int cyc      = 0;
        bit in_drain = 1'b0;
        bit done     = 1'b0;
        fifo_rdempty   = 1'b0;
        fft_sink_ready = 1'b1;
        if (stray) begin
            fft_source_valid = 1'b1;
            fft_source_sop   = 1'b0;
            fft_source_eop   = 1'b0;
            fft_source_real  = DW'($urandom);
            fft_source_imag  = DW'($urandom);
            out_ready        = 1'b1;
            #2;
            n_checks++;
            if ({fft_source_ready, out_valid} !== 2'b10) begin
                n_errors++;
                $display("FAIL stray_discard srdy/ovld got=%b want=10", {fft_source_ready, out_valid});
            end
            exp_err = 1'b1;
            step();
            fft_source_valid = 1'b0;
            #2;
            n_checks++;
            if (err !== 1'b1) begin
                n_errors++;
                $display("FAIL stray_err got=%b want=1", err);
            end
        end
        while (!done && cyc < 400) begin
            fft_source_valid = ($urandom_range(99) < 70);
            fft_source_sop   = (k == 0);
            fft_source_eop   = (k == eop_at);
            fft_source_real  = DW'($urandom);
            fft_source_imag  = DW'($urandom);
            fft_source_exp   = (k == 0) ? exp_val : 6'($urandom);
            out_ready        = ($urandom_range(99) < ready_pct);
            #2;
            if (!in_drain) begin
                n_checks++;
                if ({fft_source_ready, out_valid} !== 2'b00) begin
                    n_errors++;
                    $display("FAIL sop_not_consumed srdy/ovld got=%b want=00",
                             {fft_source_ready, out_valid});
                end
                if (fft_source_valid) in_drain = 1'b1;
            end else begin
                n_checks++;
                if ({out_valid, fft_source_ready, frame_done, fifo_rdreq} !==
                    {fft_source_valid, out_ready, 1'b0, 1'b0}) begin
                    n_errors++;
                    $display("FAIL drain_strobes beat=%0d ovld/srdy/done/rdreq got=%b want=%b", k,
                             {out_valid, fft_source_ready, frame_done, fifo_rdreq},
                             {fft_source_valid, out_ready, 1'b0, 1'b0});
                end
                if (fft_source_valid) begin
                    n_checks++;
                    if (out_data !== {fft_source_imag, fft_source_real}) begin
                        n_errors++;
                        $display("FAIL drain_data beat=%0d got=%h want=%h", k, out_data,
                                 {fft_source_imag, fft_source_real});
                    end
                end
                if (fft_source_valid && out_ready) begin
                    if (k == 0) exp_model = exp_val;
                    if (k == eop_at) begin
                        done = 1'b1;
                        if (eop_at != LEN - 1) exp_err = 1'b1;
                    end else if (k == LEN - 1) begin
                        exp_err = 1'b1;
                    end
                    k++;
                end
            end
            cyc++;
            step();
        end
        fft_source_valid = 1'b0;
        fft_source_sop   = 1'b0;
        fft_source_eop   = 1'b0;
        fifo_rdempty     = 1'b1;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout got=%0d want=%0d beats", k, eop_at + 1);
        end else begin
            #2;
            n_checks++;
            if ({frame_done, err, exp_reg} !== {1'b1, exp_err, exp_model}) begin
                n_errors++;
                $display("FAIL done_state done/err/exp got=%b/%b/%h want=1/%b/%h",
                         frame_done, err, exp_reg, exp_err, exp_model);
            end
            step();
            #2;
            n_checks++;
            if ({frame_done, busy, fft_reset_n} !== {1'b0, start, start}) begin
                n_errors++;
                $display("FAIL after_done done/busy/rstn got=%b want=%b",
                         {frame_done, busy, fft_reset_n}, {1'b0, start, start});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        quiet_inputs();
        repeat (3) step();
        reset            = 1'b0;
        fifo_rdempty     = 1'b0;
        fft_sink_ready   = 1'b1;
        fft_source_valid = 1'b1;
        out_ready        = 1'b1;
        exp_err          = 1'b0;
        exp_model        = 6'd0;
        #2;
        n_checks++;
        if ({busy, fft_reset_n, err, frame_done, out_valid, fft_sink_valid, fifo_rdreq,
             fft_source_ready} !== 8'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {busy, fft_reset_n, err, frame_done, out_valid, fft_sink_valid,
                      fifo_rdreq, fft_source_ready});
        end
        n_checks++;
        if (exp_reg !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_exp_reg got=%h want=00", exp_reg);
        end
        quiet_inputs();
        step();
    endtask

    task automatic test_single_frame();
        start = 1'b1;
        run_feed(1'b1, LEN, 0, 0);
        start = 1'b0;
        run_drain(LEN - 1, 1'b0, 50, 6'h3A);
    endtask

    task automatic test_stalls();
        start = 1'b1;
        run_feed(1'b1, LEN, 50, 50);
        start = 1'b0;
        run_drain(LEN - 1, 1'b0, 80, 6'($urandom));
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        run_feed(1'b1, LEN, 20, 20);
        run_drain(LEN - 1, 1'b0, 60, 6'($urandom));
        run_feed(1'b0, LEN, 30, 10);
        start = 1'b0;
        run_drain(LEN - 1, 1'b0, 60, 6'($urandom));
    endtask

    task automatic test_framing_errors();
        start = 1'b1;
        run_feed(1'b1, LEN, 10, 10);
        run_drain(5, 1'b0, 70, 6'($urandom));
        run_feed(1'b0, LEN, 10, 10);
        start = 1'b0;
        run_drain(LEN - 1, 1'b1, 70, 6'($urandom));
    endtask

    task automatic test_reset_mid_feed();
        start = 1'b1;
        run_feed(1'b1, 3, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        quiet_inputs();
        exp_err   = 1'b0;
        exp_model = 6'd0;
        #2;
        n_checks++;
        if ({busy, fft_reset_n, err, exp_reg} !== 9'b0) begin
            n_errors++;
            $display("FAIL mid_feed_reset busy/rstn/err/exp got=%b want=000000000",
                     {busy, fft_reset_n, err, exp_reg});
        end
        run_feed(1'b1, LEN, 30, 30);
        start = 1'b0;
        run_drain(LEN - 1, 1'b0, 70, 6'($urandom));
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stalls();
        test_back_to_back();
        test_framing_errors();
        test_reset_mid_feed();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Frame sequencer for the FFT core.
- Pulls decimated I/Q samples from the show-ahead 120→48 dual-clock FIFO (read side).
- Frames exactly FFT_LEN samples into the FFT sink with sop/eop markers.
- Waits for the transform, then drains the result frame into the 32-bit cypres-side sink interface (real/imag packed).
- Sits in the ifclk domain, between fifo_120_48 and the USB streamer.

Parameters:
FFT_LEN, 8192, samples per frame (power of two, ≥4)
CNT_W, 13, width of sample counters, log2(FFT_LEN)
STARTUP, 20, cycles the FFT core is held in reset after start
DW, 16, sample width per component

Ports:
clk  in  1  ifclk domain clock
reset  in  1  synchronous, active-high
start  in  1  level; high = run frames continuously
fifo_rdempty  in  1  FIFO empty (show-ahead: fifo_re/im valid when low)
fifo_re  in  DW  cos48 sample
fifo_im  in  DW  sin48 sample
fifo_rdreq  out  1  FIFO read acknowledge
fft_reset_n  out  1  FFT core reset, active-low
fft_sink_ready  in  1  FFT accepts input
fft_sink_valid  out  1  input sample valid
fft_sink_sop  out  1  first sample of frame
fft_sink_eop  out  1  last sample of frame
fft_sink_real  out  DW  = fifo_re
fft_sink_imag  out  DW  = fifo_im
fft_source_valid  in  1  result valid
fft_source_sop  in  1  result frame start
fft_source_eop  in  1  result frame end
fft_source_real  in  DW  result real
fft_source_imag  in  DW  result imag
fft_source_exp  in  6  block exponent
fft_source_ready  out  1  result accept
out_valid  out  1  packed result valid
out_data  out  32  {imag, real}
out_ready  in  1  downstream (cypres) ready
exp_reg  out  6  exponent captured at accepted source_sop
busy  out  1  state ≠ IDLE
frame_done  out  1  one-cycle pulse per completed output frame
err  out  1  sticky framing error, cleared only by reset

Behaviour:
Reset values:
- state=IDLE, fft_reset_n=0, counters=0, exp_reg=0, err=0, frame_done=0.
- All combinational outputs are deasserted when not in their state.

States:
- IDLE: fft_reset_n=0. If start=1 → HOLD; hold counter loads STARTUP-1.
- HOLD: fft_reset_n=0. Decrement each cycle; at 0 → FEED, with fft_reset_n=1 from the next cycle on.
- FEED:
  - fft_sink_valid = !fifo_rdempty (combinational). Data passes straight from the FIFO.
  - Transfer = fft_sink_valid & fft_sink_ready; fifo_rdreq = transfer.
  - fft_sink_sop = valid & (in_cnt==0); fft_sink_eop = valid & (in_cnt==FFT_LEN-1).
  - in_cnt increments on transfer only. Transfer at FFT_LEN-1 → in_cnt=0, → WAIT_OUT.
  - FIFO empty or sink not ready: stall, no count change, no rdreq.
- WAIT_OUT:
  - source_valid & source_sop: → DRAIN without consuming (fft_source_ready=0 this cycle).
  - source_valid & !source_sop: stray beat. Discard with fft_source_ready=1 and set err.
- DRAIN:
  - fft_source_ready = out_ready; out_valid = fft_source_valid; out_data = {fft_source_imag, fft_source_real}.
  - Beat = out_valid & out_ready; out_cnt increments per beat.
  - Beat with source_sop: exp_reg ← fft_source_exp.
  - Beat with source_eop: → DONE. If out_cnt ≠ FFT_LEN-1, set err.
  - out_cnt reaches FFT_LEN-1 without eop on that beat: set err; remain in DRAIN until eop.
- DONE: frame_done=1 for one cycle; out_cnt=0. start=1 → FEED (no core reset); start=0 → IDLE.

Boundary rules:
- start dropping mid-frame does not abort; the frame completes, then IDLE.
- reset in any state returns to IDLE next cycle; fft_reset_n=0 immediately registered.
- FIFO input is not read outside FEED; FIFO overflow is the producer's concern.
- Latency FIFO→sink: 0 cycles (combinational). Source→out: 0 cycles.

Test Plan:
1. FFT_LEN=8, STARTUP=4, start=1, FIFO never empty, sink_ready=1 → fft_reset_n low 4 cycles after HOLD entry; 8 consecutive transfers; sop on sample 0, eop on sample 7; 8 rdreq pulses.
2. FIFO empty every other cycle plus sink_ready toggling → exactly 8 transfers; no rdreq while empty or not ready; sop/eop only on accepted beats 0/7.
3. Source frame of 8 beats, exp=6'h3A on sop, out_ready 50% random → 8 out beats with out_data={imag,real}; exp_reg=3A; frame_done single pulse; err=0.
4. start held high over two frames → second FEED follows DONE directly; fft_reset_n stays 1; two frame_done pulses.
5. Source eop on beat 5 → err=1 sticky; DONE entered. Stray source_valid without sop in WAIT_OUT → discarded; err=1.
6. reset asserted mid-FEED (in_cnt=3) → next cycle IDLE, fft_reset_n=0, counters 0; restarting start gives a clean frame beginning with sop.
